// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART encodings, divisor helper and receiver state encodings
// Used by both the Tx and Rx sides.
//   baud_sel_e  : 2-bit baud select (2400/4800/9600/19200)
//   parity_e    : 2-bit parity select (none/odd/even/none)
//   rx_state_e  : receiver FSM states
//   baud_divisor: clocks per oversample tick, truncated
package uart_pkg;

    localparam int DIV_W = 16;

    localparam int BAUD_HZ_2400  = 2400;
    localparam int BAUD_HZ_4800  = 4800;
    localparam int BAUD_HZ_9600  = 9600;
    localparam int BAUD_HZ_19200 = 19200;

    typedef enum logic [1:0] {
        BAUD_2400  = 2'b00,
        BAUD_4800  = 2'b01,
        BAUD_9600  = 2'b10,
        BAUD_19200 = 2'b11
    } baud_sel_e;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_ODD      = 2'b01,
        PAR_EVEN     = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP1,
        RX_STOP2
    } rx_state_e;

    function automatic logic [DIV_W-1:0] baud_divisor(input int clk_freq, input int oversample,
                                                      input int baud_hz);
        return DIV_W'(clk_freq / (baud_hz * oversample));
    endfunction

    function automatic logic parity_enabled(input logic [1:0] p);
        return (p == PAR_ODD) || (p == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// rtl/uart_rx_tick_gen.sv - oversample tick enable generator for the UART receiver
// Ports:
//   clk_i      : system clock
//   rst_i      : asynchronous active-high reset
//   en_i       : counter runs only while high; held at zero otherwise
//   baud_sel_i : latched baud select
//   tick_o     : one-cycle pulse every divisor clocks
module uart_rx_tick_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] baud_sel_i,
    output logic       tick_o
);

    localparam logic [DIV_W-1:0] DIV_2400  = baud_divisor(CLK_FREQ, OVERSAMPLE, BAUD_HZ_2400);
    localparam logic [DIV_W-1:0] DIV_4800  = baud_divisor(CLK_FREQ, OVERSAMPLE, BAUD_HZ_4800);
    localparam logic [DIV_W-1:0] DIV_9600  = baud_divisor(CLK_FREQ, OVERSAMPLE, BAUD_HZ_9600);
    localparam logic [DIV_W-1:0] DIV_19200 = baud_divisor(CLK_FREQ, OVERSAMPLE, BAUD_HZ_19200);

    logic [DIV_W-1:0] div_sel;
    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        case (baud_sel_i)
            BAUD_2400: div_sel = DIV_2400;
            BAUD_4800: div_sel = DIV_4800;
            BAUD_9600: div_sel = DIV_9600;
            default:   div_sel = DIV_19200;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q >= div_sel - DIV_W'(1)) begin
            cnt_d  = '0;
            tick_o = 1'b1;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx_unit.sv
// rtl/uart_rx_unit.sv - UART receiver: sync, 16x oversampled deframing, parity/stop checks
// Optional macro RX_MAJORITY_EN: bit value is 2-of-3 majority of ticks 7, 8, 9 (else tick 8 only).
// Ports:
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   rx_i                    : serial line, idle high, asynchronous
//   baud_rate_i             : 00=2400 01=4800 10=9600 11=19200
//   parity_type_i           : 00/11 none, 01 odd, 10 even
//   data_length_i           : 0=7 bits, 1=8 bits
//   stop_bits_i             : 0=one stop, 1=two stops
//   data_out_o              : received word (bit7=0 in 7-bit mode)
//   done_flag_o             : one-cycle frame-complete pulse
//   active_flag_o           : frame in progress
//   parity_error_o          : parity mismatch on last frame
//   stop_error_o            : a stop bit sampled low on last frame
module uart_rx_unit
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    input  logic [1:0] baud_rate_i,
    input  logic [1:0] parity_type_i,
    input  logic       data_length_i,
    input  logic       stop_bits_i,
    output logic [7:0] data_out_o,
    output logic       done_flag_o,
    output logic       active_flag_o,
    output logic       parity_error_o,
    output logic       stop_error_o
);

    localparam int TCW = $clog2(OVERSAMPLE);
    // Tick counter values: 7th, 8th and 9th tick of a bit; the bit is resolved on the 9th
    // in both build variants so frame latency does not depend on the macro.
    localparam logic [TCW-1:0] T_S7  = TCW'(OVERSAMPLE / 2 - 2);
    localparam logic [TCW-1:0] T_S8  = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0] T_DEC = TCW'(OVERSAMPLE / 2);
    localparam logic [TCW-1:0] T_END = TCW'(OVERSAMPLE - 1);

    rx_state_e        state_q, state_d;
    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    logic [TCW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [1:0]       samp_q, samp_d;
    logic             par_bad_q, par_bad_d;
    logic             stop_err_q, stop_err_d;
    logic [1:0]       baud_q, baud_d, par_q, par_d;
    logic             len_q, len_d, stop2_q, stop2_d;
    logic [7:0]       data_q, data_d;
    logic             perr_q, perr_d, serr_q, serr_d, done_q, done_d;
    logic             tick, fall, at_dec, at_end, bit_val, exp_par, finish;
    logic [2:0]       last_bit;

    uart_rx_tick_gen #(
        .CLK_FREQ   (CLK_FREQ),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick_gen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (state_q != RX_IDLE),
        .baud_sel_i (baud_q),
        .tick_o     (tick)
    );

    // rx_prev_q keeps tracking the line mid-frame, so a low line after a frame never
    // looks like a new start edge until it has been seen high again.
    assign fall     = rx_prev_q & ~rx_s2_q;
    assign at_dec   = tick && (tick_cnt_q == T_DEC);
    assign at_end   = tick && (tick_cnt_q == T_END);
    assign last_bit = len_q ? 3'd7 : 3'd6;
    assign exp_par  = (par_q == PAR_EVEN) ? ^shift_q : ~^shift_q;

`ifdef RX_MAJORITY_EN
    assign bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s2_q) | (samp_q[1] & rx_s2_q);
`else
    assign bit_val = samp_q[1];
`endif

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        samp_d     = samp_q;
        par_bad_d  = par_bad_q;
        stop_err_d = stop_err_q;
        baud_d     = baud_q;
        par_d      = par_q;
        len_d      = len_q;
        stop2_d    = stop2_q;
        data_d     = data_q;
        perr_d     = perr_q;
        serr_d     = serr_q;
        done_d     = 1'b0;
        finish     = 1'b0;

        if (state_q == RX_IDLE)  tick_cnt_d = '0;
        else if (tick)           tick_cnt_d = (tick_cnt_q == T_END) ? '0 : tick_cnt_q + TCW'(1);
        if (tick && tick_cnt_q == T_S7) samp_d[0] = rx_s2_q;
        if (tick && tick_cnt_q == T_S8) samp_d[1] = rx_s2_q;

        case (state_q)
            RX_IDLE: begin
                if (fall) begin
                    state_d    = RX_START;
                    baud_d     = baud_rate_i;
                    par_d      = parity_type_i;
                    len_d      = data_length_i;
                    stop2_d    = stop_bits_i;
                    bit_cnt_d  = '0;
                    shift_d    = '0;
                    par_bad_d  = 1'b0;
                    stop_err_d = 1'b0;
                end
            end
            RX_START: begin
                if (at_dec && bit_val) state_d = RX_IDLE;   // glitch: outputs untouched
                else if (at_end)       state_d = RX_DATA;
            end
            RX_DATA: begin
                if (at_dec) shift_d[bit_cnt_q] = bit_val;
                if (at_end) begin
                    if (bit_cnt_q == last_bit)
                        state_d = parity_enabled(par_q) ? RX_PARITY : RX_STOP1;
                    else
                        bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            RX_PARITY: begin
                if (at_dec) par_bad_d = (bit_val != exp_par);
                if (at_end) state_d = RX_STOP1;
            end
            RX_STOP1: begin
                if (at_dec) begin
                    if (stop2_q) stop_err_d = stop_err_q | ~bit_val;
                    else         finish = 1'b1;
                end
                if (at_end) state_d = RX_STOP2;
            end
            RX_STOP2: begin
                if (at_dec) finish = 1'b1;
            end
            default: state_d = RX_IDLE;
        endcase

        // Frame ends at the last stop-bit sample, not at the end of the bit, so a start
        // edge arriving right after is seen from IDLE.
        if (finish) begin
            state_d = RX_IDLE;
            data_d  = shift_q;
            perr_d  = par_bad_q;
            serr_d  = stop_err_q | ~bit_val;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= RX_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            samp_q     <= 2'b11;
            par_bad_q  <= 1'b0;
            stop_err_q <= 1'b0;
            baud_q     <= '0;
            par_q      <= '0;
            len_q      <= 1'b0;
            stop2_q    <= 1'b0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rx_s1_q    <= rx_i;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            samp_q     <= samp_d;
            par_bad_q  <= par_bad_d;
            stop_err_q <= stop_err_d;
            baud_q     <= baud_d;
            par_q      <= par_d;
            len_q      <= len_d;
            stop2_q    <= stop2_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
            done_q     <= done_d;
        end
    end

    assign data_out_o     = data_q;
    assign done_flag_o    = done_q;
    assign active_flag_o  = (state_q != RX_IDLE);
    assign parity_error_o = perr_q;
    assign stop_error_o   = serr_q;

endmodule

// File: tb/tb_uart_rx_unit.sv
// tb/tb_uart_rx_unit.sv - scoreboard testbench for uart_rx_unit
module tb_uart_rx_unit;

    localparam int CLK_FREQ = 614_400;   // divisors 16/8/4/2
    localparam int OS       = 16;

    logic       clk = 1'b0;
    logic       rst, rx;
    logic [1:0] baud, par;
    logic       len, stop2;
    logic [7:0] data_out;
    logic       done, active, perr, serr;

    always #5 clk = ~clk;

    uart_rx_unit #(.CLK_FREQ(CLK_FREQ), .OVERSAMPLE(OS)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .rx_i           (rx),
        .baud_rate_i    (baud),
        .parity_type_i  (par),
        .data_length_i  (len),
        .stop_bits_i    (stop2),
        .data_out_o     (data_out),
        .done_flag_o    (done),
        .active_flag_o  (active),
        .parity_error_o (perr),
        .stop_error_o   (serr)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       serr;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic int div_of(input logic [1:0] b);
        return CLK_FREQ / ((2400 << b) * OS);
    endfunction

    // Monitor: every DoneFlag pops one expected frame.
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            check("done_single_cycle", 32'(prev_done), 0);
            check("active_low_at_done", 32'(active), 0);
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done actual=data 0x%0h required=no frame", data_out);
            end else begin
                e = sb_q.pop_front();
                check("frame_data_perr_serr", 32'({data_out, perr, serr}), 32'(e));
            end
        end
        prev_done <= done;
    end

    // Drives one frame, one line value per negedge. glitch_t forces a single low clock,
    // abort_t asserts reset at that clock, hold_low keeps the line low afterwards.
    task automatic send_frame(input logic [1:0] b, input logic [1:0] p, input logic l,
                              input logic s2, input logic [7:0] byt, input logic flip,
                              input logic [1:0] stop_low, input int glitch_t,
                              input int abort_t, input int hold_low);
        logic bits[$];
        int   d, bt, total, nd;
        logic pbit, has_p;
        logic [7:0] m;
        exp_t e;
        nd    = l ? 8 : 7;
        m     = l ? 8'hFF : 8'h7F;
        has_p = (p == 2'b01) || (p == 2'b10);
        d     = div_of(b);
        bt    = 16 * d;
        bits.push_back(1'b0);
        for (int i = 0; i < nd; i++) bits.push_back(byt[i]);
        if (has_p) begin
            pbit = ^(byt & m);
            if (p == 2'b01) pbit = ~pbit;
            bits.push_back(pbit ^ flip);
        end
        bits.push_back(~stop_low[0]);
        if (s2) bits.push_back(~stop_low[1]);
        e.data = byt & m;
        e.perr = has_p & flip;
        e.serr = stop_low[0] | (s2 & stop_low[1]);
`ifndef RX_MAJORITY_EN
        if (glitch_t >= 0 && (glitch_t % bt) == 8 * d && glitch_t / bt >= 1 && glitch_t / bt <= nd)
            e.data[glitch_t / bt - 1] = 1'b0;
`endif
        baud = b; par = p; len = l; stop2 = s2;
        if (abort_t < 0) begin
            sb_q.push_back(e);
            last_exp = e;
        end
        total = bits.size() * bt;
        for (int t = 0; t < total; t++) begin
            @(negedge clk);
            if (t == abort_t) begin
                rst = 1'b1;
                rx  = 1'b1;
                #1;
                check("reset_clears_outputs", 32'({data_out, done, active, perr, serr}), 0);
                repeat (3) @(negedge clk);
                rst = 1'b0;
                last_exp = '0;
                repeat (2 * bt) @(negedge clk);
                return;
            end
            if (t % bt == 4 * d) check("active_in_frame", 32'(active), 1);
            if (t == 20 * d) begin
                baud  = 2'($urandom_range(0, 3));
                par   = 2'($urandom_range(0, 3));
                len   = 1'($urandom_range(0, 1));
                stop2 = 1'($urandom_range(0, 1));
            end
            rx = (t == glitch_t) ? 1'b0 : bits[t / bt];
        end
        if (hold_low > 0) begin
            rx = 1'b0;
            repeat (hold_low) @(negedge clk);
            check("active_low_during_break", 32'(active), 0);
        end
        rx = 1'b1;
        repeat (2 * bt) @(negedge clk);
        check("active_low_when_idle", 32'(active), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rx = 1'b1; baud = 2'b10; par = 2'b00; len = 1'b1; stop2 = 1'b0;
        last_exp = '0;
        repeat (3) @(negedge clk);
        check("reset_state", 32'({data_out, done, active, perr, serr}), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_after_reset", 32'(active), 0);

        // 8N1 9600 0xA5
        send_frame(2'b10, 2'b00, 1'b1, 1'b0, 8'hA5, 1'b0, 2'b00, -1, -1, 0);
        // 7E2 0x35, good parity then bad parity
        send_frame(2'b10, 2'b10, 1'b0, 1'b1, 8'h35, 1'b0, 2'b00, -1, -1, 0);
        send_frame(2'b10, 2'b10, 1'b0, 1'b1, 8'h35, 1'b1, 2'b00, -1, -1, 0);
        // reset inside data bit 3 (after three data bits), then 0x3C
        send_frame(2'b10, 2'b00, 1'b1, 1'b0, 8'h5A, 1'b0, 2'b00, -1, 4 * 64 + 8, 0);
        send_frame(2'b10, 2'b00, 1'b1, 1'b0, 8'h3C, 1'b0, 2'b00, -1, -1, 0);
        // 8O1 0x00 with low stop bit, then line held low three frame times
        send_frame(2'b10, 2'b01, 1'b1, 1'b0, 8'h00, 1'b0, 2'b01, -1, -1, 3 * 11 * 64);

        // 4-tick low pulse on an idle line
        baud = 2'b10;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        check("active_during_false_start", 32'(active), 1);
        repeat (3 * 64) @(negedge clk);
        check("active_after_false_start", 32'(active), 0);
        check("outputs_kept_false_start", 32'({data_out, perr, serr}), 32'(last_exp));

        // one-clock glitch at tick 8 of data bit 2 of 0xFF
        send_frame(2'b10, 2'b00, 1'b1, 1'b0, 8'hFF, 1'b0, 2'b00, 3 * 64 + 8 * 4, -1, 0);

        for (int k = 0; k < 10; k++) begin
            send_frame(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                       -1, -1, 0);
        end

        repeat (50) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
